// File: rtl/mp64_sram_copy_dma.sv
// Block copy/fill engine driving both ports of a dual-port SRAM: copy reads port A
// and writes port B at one word per clock; fill writes a constant through port B only.
module mp64_sram_copy_dma #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              ce_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] rdata_a,
  output logic              ce_b,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W-1:0] rdata_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;

  state_e              state_q, state_d;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   fill_q;
  logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic                aborted_q, aborted_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
  logic [DATA_W-1:0]   wdata_b_q;
  logic                rd_go, wr_go, kill;
  logic                unused_rdata_b;

  assign unused_rdata_b = ^rdata_b;
  assign kill = abort && (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    aborted_d = 1'b0;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (mode_q) wr_go = 1'b1;
        else        rd_go = 1'b1;
      end
      S_DRAIN: state_d = S_DRAIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Copy writes follow the read-valid pipe, in RUN as well as DRAIN.
    if (!mode_q && (state_q == S_RUN || state_q == S_DRAIN) && pipe_q[RD_LAT-1])
      wr_go = 1'b1;
    if (rd_go) rd_cnt_d = rd_cnt_q + 1'b1;
    if (wr_go) wr_cnt_d = wr_cnt_q + 1'b1;

    if (state_q == S_RUN && !mode_q && rd_cnt_q == len_q - 1'b1)
      state_d = S_DRAIN;
    if ((state_q == S_DRAIN || (state_q == S_RUN && mode_q)) && wr_cnt_d == len_q)
      state_d = S_FIN;

    pipe_d[0] = rd_go;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (kill) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
      pipe_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      pipe_q    <= '0;
      aborted_q <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      pipe_q    <= pipe_d;
      aborted_q <= aborted_d;
      addr_a_q  <= addr_a;
      addr_b_q  <= addr_b;
      wdata_b_q <= wdata_b;
      if (state_q == S_IDLE && start) begin
        mode_q <= mode;
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        len_q  <= len;
        fill_q <= fill_data;
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN) && !abort;
  assign aborted = aborted_q;

  // Idle ports keep their last address/data so the SRAM pins do not toggle.
  assign ce_a    = rd_go;
  assign we_a    = 1'b0;
  assign wdata_a = '0;
  assign addr_a  = rd_go ? (src_q + rd_cnt_q[ADDR_W-1:0]) : addr_a_q;

  assign ce_b    = wr_go;
  assign we_b    = wr_go;
  assign addr_b  = wr_go ? (dst_q + wr_cnt_q[ADDR_W-1:0]) : addr_b_q;
  assign wdata_b = !wr_go ? wdata_b_q : (mode_q ? fill_q : rdata_a);

endmodule

// File: tb/tb_mp64_sram_copy_dma.sv
// Bench for mp64_sram_copy_dma: one instance per legal read latency, each with its own
// behavioural dual-port SRAM and an independent expected-memory image.
module tb_mp64_sram_copy_dma;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, mode, abort;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] fill_data;
  logic [DW-1:0] rdata_b_tie;
  assign rdata_b_tie = '0;

  logic          busy [2], done [2], aborted [2], ce_a [2], we_a [2], ce_b [2], we_b [2];
  logic [AW-1:0] addr_a [2], addr_b [2];
  logic [DW-1:0] wdata_a [2], wdata_b [2], rdata_a [2];

  logic [DW-1:0] mem [2][N];
  logic [DW-1:0] exp_mem [2][N];
  logic [DW-1:0] rd_s1 [2], rd_s2 [2];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  mp64_sram_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_data(fill_data), .abort(abort), .busy(busy[0]), .done(done[0]),
    .aborted(aborted[0]), .ce_a(ce_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]),
    .wdata_a(wdata_a[0]), .rdata_a(rdata_a[0]), .ce_b(ce_b[0]), .we_b(we_b[0]),
    .addr_b(addr_b[0]), .wdata_b(wdata_b[0]), .rdata_b(rdata_b_tie)
  );

  mp64_sram_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_data(fill_data), .abort(abort), .busy(busy[1]), .done(done[1]),
    .aborted(aborted[1]), .ce_a(ce_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]),
    .wdata_a(wdata_a[1]), .rdata_a(rdata_a[1]), .ce_b(ce_b[1]), .we_b(we_b[1]),
    .addr_b(addr_b[1]), .wdata_b(wdata_b[1]), .rdata_b(rdata_b_tie)
  );

  // SRAM models: instance 0 has one read stage, instance 1 adds an output register.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pre_we) mem[k][pre_addr] <= pre_data;
      else if (ce_b[k] && we_b[k]) mem[k][addr_b[k]] <= wdata_b[k];
      if (ce_a[k] && !we_a[k]) rd_s1[k] <= mem[k][addr_a[k]];
      rd_s2[k] <= rd_s1[k];
    end
  end
  assign rdata_a[0] = rd_s1[0];
  assign rdata_a[1] = rd_s2[1];

  typedef struct {
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] fill;
    logic          abort0;
    int            done1;
    int            done2;
    int            fw1;
    int            fw2;
  } vec_t;

  vec_t tbl [7];
  int   checks = 0;
  int   errors = 0;
  int   busy_n [2], done_n [2], done_c [2], ab_n [2], ab_c [2];
  int   rd_n [2], wr_n [2], fw [2], wea_n [2], addr_err [2];
  logic [10:0] snap [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs(input int k);
    return {busy[k], done[k], aborted[k], ce_a[k], we_a[k], ce_b[k], we_b[k],
            |addr_a[k], |addr_b[k], |wdata_a[k], |wdata_b[k]};
  endfunction

  function automatic int mem_diff(input int k);
    int n = 0;
    for (int i = 0; i < N; i++) if (mem[k][i] !== exp_mem[k][i]) n++;
    return n;
  endfunction

  task automatic apply_copy(input int k, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_mem[k][d + AW'(i)] = exp_mem[k][s + AW'(i)];
  endtask

  task automatic apply_fill(input int k, input logic [AW-1:0] d, input logic [DW-1:0] f, input int n);
    for (int i = 0; i < n; i++) exp_mem[k][d + AW'(i)] = f;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
    exp_mem[0][a] = d;
    exp_mem[1][a] = d;
  endtask

  // Cycle 0 carries the start strobe; cycles 1..ncyc are sampled 1 time unit after the falling edge.
  task automatic run_job(input vec_t v, input int abort_cyc, input int xstart_cyc,
                         input int rst_cyc, input int ncyc);
    for (int k = 0; k < 2; k++) begin
      busy_n[k] = 0; done_n[k] = 0; done_c[k] = -1; ab_n[k] = 0; ab_c[k] = -1;
      rd_n[k] = 0; wr_n[k] = 0; fw[k] = -1; wea_n[k] = 0; addr_err[k] = 0; snap[k] = '0;
    end
    @(negedge clk);
    start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
    len = v.len; fill_data = v.fill; abort = v.abort0;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == xstart_cyc);
      if (start) begin
        mode = 1'b1; dst_addr = 14'h0400; len = 15'd2; fill_data = 64'h1111_2222_3333_4444;
      end
      abort = (c == abort_cyc);
      rst   = (c == rst_cyc);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) busy_n[k]++;
        if (done[k]) begin done_n[k]++; done_c[k] = c; end
        if (aborted[k]) begin ab_n[k]++; ab_c[k] = c; end
        if (ce_a[k]) rd_n[k]++;
        if (we_a[k]) wea_n[k]++;
        if (ce_b[k] && we_b[k]) begin
          if (fw[k] < 0) fw[k] = c;
          if (addr_b[k] != v.dst + AW'(wr_n[k])) addr_err[k]++;
          wr_n[k]++;
        end
        if (c == rst_cyc + 1) snap[k] = outs(k);
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic check_job(input string tag, input vec_t v);
    int ed, efw, n;
    n = int'(v.len);
    for (int k = 0; k < 2; k++) begin
      ed  = (k == 0) ? v.done1 : v.done2;
      efw = (k == 0) ? v.fw1 : v.fw2;
      if (v.mode) apply_fill(k, v.dst, v.fill, n);
      else        apply_copy(k, v.src, v.dst, n);
      check($sformatf("%s dut%0d done_cycle", tag, k + 1), done_c[k], ed);
      check($sformatf("%s dut%0d done_pulses", tag, k + 1), done_n[k], 1);
      check($sformatf("%s dut%0d busy_cycles", tag, k + 1), busy_n[k], ed);
      check($sformatf("%s dut%0d reads", tag, k + 1), rd_n[k], v.mode ? 0 : n);
      check($sformatf("%s dut%0d writes", tag, k + 1), wr_n[k], n);
      check($sformatf("%s dut%0d first_write", tag, k + 1), fw[k], efw);
      check($sformatf("%s dut%0d aborted_pulses", tag, k + 1), ab_n[k], 0);
      check($sformatf("%s dut%0d we_a_cycles", tag, k + 1), wea_n[k], 0);
      check($sformatf("%s dut%0d addr_b_errors", tag, k + 1), addr_err[k], 0);
      check($sformatf("%s dut%0d mem_diffs", tag, k + 1), mem_diff(k), 0);
    end
  endtask

  initial begin
    vec_t va, vb, vc;
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    //             mode  src       dst       len        fill                     ab0   d1     d2     fw1 fw2
    tbl[0] = '{1'b1, 14'h0000, 14'h1234, 15'd16384, 64'h5A5A_0F0F_3C3C_9696, 1'b0, 16385, 16385, 1, 1};
    tbl[1] = '{1'b0, 14'h0010, 14'h0100, 15'd4,     64'h0,                   1'b0, 6,     7,     2, 3};
    tbl[2] = '{1'b1, 14'h0000, 14'h3FFE, 15'd4,     64'hDEAD_BEEF_CAFE_F00D, 1'b0, 5,     5,     1, 1};
    tbl[3] = '{1'b0, 14'h0020, 14'h0200, 15'd0,     64'h0,                   1'b0, 1,     1,     -1, -1};
    tbl[4] = '{1'b0, 14'h0013, 14'h2000, 15'd1,     64'h0,                   1'b1, 3,     4,     2, 3};
    tbl[5] = '{1'b0, 14'h3FFC, 14'h1000, 15'd6,     64'h0,                   1'b0, 8,     9,     2, 3};
    tbl[6] = '{1'b0, 14'h0101, 14'h0100, 15'd3,     64'h0,                   1'b0, 5,     6,     2, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("reset dut%0d outputs", k + 1), int'(outs(k)), 0);

    // The first job fills every word, giving both SRAM models a known image.
    for (int i = 0; i < 7; i++) begin
      if (i == 1)
        for (int j = 0; j < 8; j++) preload(14'h0010 + AW'(j), 64'hA0A0_0000_0000_0000 + DW'(j));
      run_job(tbl[i], -1, -1, -1, int'(tbl[i].len) + 6);
      check_job($sformatf("v%0d", i), tbl[i]);
    end

    // Abort in the third busy cycle of an 8-word copy, with an ignored start in cycle 2.
    va = '{1'b0, 14'h0010, 14'h0300, 15'd8, 64'h0, 1'b0, 0, 0, 0, 0};
    run_job(va, 3, 2, -1, 10);
    apply_copy(0, va.src, va.dst, 2);
    apply_copy(1, va.src, va.dst, 1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort dut%0d writes", k + 1), wr_n[k], (k == 0) ? 2 : 1);
      check($sformatf("abort dut%0d reads", k + 1), rd_n[k], 3);
      check($sformatf("abort dut%0d done_pulses", k + 1), done_n[k], 0);
      check($sformatf("abort dut%0d aborted_pulses", k + 1), ab_n[k], 1);
      check($sformatf("abort dut%0d aborted_cycle", k + 1), ab_c[k], 4);
      check($sformatf("abort dut%0d busy_cycles", k + 1), busy_n[k], 3);
      check($sformatf("abort dut%0d addr_b_errors", k + 1), addr_err[k], 0);
      check($sformatf("abort dut%0d mem_diffs", k + 1), mem_diff(k), 0);
    end

    // Reset in the third busy cycle, then a fresh job.
    vb = '{1'b0, 14'h0010, 14'h0500, 15'd8, 64'h0, 1'b0, 0, 0, 0, 0};
    run_job(vb, -1, -1, 3, 10);
    apply_copy(0, vb.src, vb.dst, 2);
    apply_copy(1, vb.src, vb.dst, 1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst dut%0d outputs_after", k + 1), int'(snap[k]), 0);
      check($sformatf("rst dut%0d writes", k + 1), wr_n[k], (k == 0) ? 2 : 1);
      check($sformatf("rst dut%0d done_pulses", k + 1), done_n[k], 0);
      check($sformatf("rst dut%0d aborted_pulses", k + 1), ab_n[k], 0);
      check($sformatf("rst dut%0d mem_diffs", k + 1), mem_diff(k), 0);
    end
    vc = '{1'b0, 14'h0014, 14'h0600, 15'd4, 64'h0, 1'b0, 6, 7, 2, 3};
    run_job(vc, -1, -1, -1, 10);
    check_job("post_rst", vc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
